// File: rtl/pipe_fetch_decode.sv
// Instruction fetch/decode front end.
// Holds a loadable instruction memory and a PC, issues one decoded slot per clock,
// inserts bubbles for RAW hazards (no downstream forwarding) and drains on HALT.
module pipe_fetch_decode #(
    parameter int          DEPTH       = 256,
    parameter logic [7:0]  BUBBLE_ADDR = 8'hFF,
    parameter int          DRAIN_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [23:0] prog_data,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic [7:0]  pc,
    output logic        stall,
    output logic        busy,
    output logic        done
);

    localparam int         PW        = $clog2(DEPTH);
    localparam int         CW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [3:0] FUNC_PASS = 4'b0011;
    localparam logic [3:0] FUNC_HALT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      rs1_q, rs1_d;
    logic [3:0]      rs2_q, rs2_d;
    logic [3:0]      rd_q, rd_d;
    logic [3:0]      func_q, func_d;
    logic [7:0]      addr_q, addr_d;
    logic            stall_q, stall_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            h0_v_q, h0_v_d;
    logic [3:0]      h0_rd_q, h0_rd_d;
    logic            h1_v_q, h1_v_d;
    logic [3:0]      h1_rd_q, h1_rd_d;

    logic [23:0]     mem_q [DEPTH];
    logic [23:0]     inst;
    logic [3:0]      inst_func, inst_rd, inst_rs1, inst_rs2;
    logic [7:0]      inst_addr;
    logic            hazard;
    logic            issue;
    logic            hist_clr;
    logic            prog_ok;

    // Program writes are only accepted while the core is not executing
    assign prog_ok = (state_q == S_IDLE) || (state_q == S_DONE);

    // Instruction memory: no reset, synchronous write, combinational read
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem_q[prog_addr[PW-1:0]] <= prog_data;
        end
    end

    assign inst      = mem_q[pc_q];
    assign inst_func = inst[23:20];
    assign inst_rd   = inst[19:16];
    assign inst_rs1  = inst[15:12];
    assign inst_rs2  = inst[11:8];
    assign inst_addr = inst[7:0];

    // Both source fields are checked against the last two real issues, whatever the func
    assign hazard = (h0_v_q && ((inst_rs1 == h0_rd_q) || (inst_rs2 == h0_rd_q)))
                 || (h1_v_q && ((inst_rs1 == h1_rd_q) || (inst_rs2 == h1_rd_q)));

    // Next-state, next-slot and hazard-history computation
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        stall_d  = 1'b0;
        issue    = 1'b0;
        hist_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (inst_func == FUNC_HALT) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (hazard) begin
                    stall_d = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (pc_q == PW'(DEPTH - 1)) begin
                        // Last word issued: drain instead of wrapping to 0
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    pc_d     = '0;
                    hist_clr = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            rs1_d  = inst_rs1;
            rs2_d  = inst_rs2;
            rd_d   = inst_rd;
            func_d = inst_func;
            addr_d = inst_addr;
        end else begin
            rs1_d  = 4'd0;
            rs2_d  = 4'd0;
            rd_d   = 4'd0;
            func_d = FUNC_PASS;
            addr_d = BUBBLE_ADDR;
        end

        if (hist_clr) begin
            h1_v_d  = 1'b0;
            h1_rd_d = 4'd0;
            h0_v_d  = 1'b0;
            h0_rd_d = 4'd0;
        end else begin
            h1_v_d  = h0_v_q;
            h1_rd_d = h0_rd_q;
            h0_v_d  = issue;
            h0_rd_d = rd_d;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State, PC, history and registered slot outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            rs1_q   <= 4'd0;
            rs2_q   <= 4'd0;
            rd_q    <= 4'd0;
            func_q  <= FUNC_PASS;
            addr_q  <= BUBBLE_ADDR;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            h0_v_q  <= 1'b0;
            h0_rd_q <= 4'd0;
            h1_v_q  <= 1'b0;
            h1_rd_q <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            func_q  <= func_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            h0_v_q  <= h0_v_d;
            h0_rd_q <= h0_rd_d;
            h1_v_q  <= h1_v_d;
            h1_rd_q <= h1_rd_d;
        end
    end

    assign rs1   = rs1_q;
    assign rs2   = rs2_q;
    assign rd    = rd_q;
    assign func  = func_q;
    assign addr  = addr_q;
    assign pc    = 8'(pc_q);
    assign stall = stall_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
